// File: rtl/forwarder_reader.sv
// forwarder_reader: streams a filled packet buffer out as 64-bit beats through a 2-entry FIFO.
// Optional m_tkeep port and final-beat byte enables are enabled by defining FWD_TKEEP_EN.
module forwarder_reader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_valid,
    input  logic [ADDR_WIDTH+3:0] byte_length,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [63:0]           m_tdata,
`ifdef FWD_TKEEP_EN
    output logic [7:0]            m_tkeep,
`endif
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
);
    localparam int LW = ADDR_WIDTH + 4;
    localparam logic [LW-1:0] MAX_LEN = LW'(8) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   words;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  inflight;
    logic                  inflight_last;
    logic                  cool;
    logic [1:0]            count;
    logic                  wptr;
    logic                  rptr;
    logic [63:0]           fifo_data [2];
    logic                  fifo_last [2];
    logic [LW-1:0]         len;
    logic [ADDR_WIDTH:0]   len_words;
    logic                  pop;
    logic                  issue;
    logic                  last_rd;

    assign len       = byte_length > MAX_LEN ? MAX_LEN : byte_length;
    assign len_words = len[LW-1:3] + (ADDR_WIDTH+1)'(|len[2:0]);
    assign pop       = m_tvalid & m_tready;
    assign last_rd   = {1'b0, addr} == words - (ADDR_WIDTH+1)'(1);
    // Reserve a FIFO slot for every read whose data has not landed yet.
    assign issue     = state == STREAM && 3'(count) + 3'(inflight) - 3'(pop) < 3'd2;

    assign forwarder_rd_en   = issue;
    assign forwarder_rd_addr = addr;
    assign m_tvalid          = count != 2'd0;
    assign m_tdata           = m_tvalid ? fifo_data[rptr] : 64'd0;
    assign m_tlast           = m_tvalid & fifo_last[rptr];

`ifdef FWD_TKEEP_EN
    logic [7:0] last_keep;
    logic [3:0] tail;

    assign tail    = {1'b0, 3'(len[2:0] - 3'd1)} + 4'd1;
    assign m_tkeep = !m_tvalid ? 8'h00 : m_tlast ? last_keep : 8'hFF;

    always_ff @(posedge clk)
        if (rst) last_keep <= 8'h00;
        else if (state == IDLE && !cool && buf_valid) last_keep <= 8'hFF << (4'd8 - tail);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            words          <= '0;
            addr           <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            cool           <= 1'b0;
            count          <= 2'd0;
            wptr           <= 1'b0;
            rptr           <= 1'b0;
            forwarder_done <= 1'b0;
        end else begin
            forwarder_done <= 1'b0;
            inflight       <= issue;
            inflight_last  <= issue & last_rd;
            count          <= count + 2'(inflight) - 2'(pop);
            if (inflight) begin
                fifo_data[wptr] <= forwarder_rd_data;
                fifo_last[wptr] <= inflight_last;
                wptr            <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case (state)
                IDLE: begin
                    cool <= 1'b0;
                    // cool marks the swap slot right after DONE, where buf_valid is ignored
                    if (!cool && buf_valid) begin
                        words          <= len_words;
                        addr           <= '0;
                        state          <= len_words == '0 ? DONE : STREAM;
                        forwarder_done <= len_words == '0;
                    end
                end
                STREAM: if (issue) begin
                    if (last_rd) state <= DRAIN;
                    else addr <= addr + ADDR_WIDTH'(1);
                end
                DRAIN: if (pop && m_tlast) begin
                    state          <= DONE;
                    forwarder_done <= 1'b1;
                end
                DONE: begin
                    cool  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_forwarder_reader.sv
// tb_forwarder_reader: scoreboard bench for forwarder_reader (ADDR_WIDTH=4, 128-byte buffer).
module tb_forwarder_reader;
    localparam int AW = 4;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [7:0]  k;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          buf_valid = 1'b0;
    logic [AW+3:0] byte_length = '0;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [63:0]   rd_data = 64'd0;
    logic          done;
    logic [63:0]   m_tdata;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
`ifdef FWD_TKEEP_EN
    logic [7:0]    m_tkeep;
`endif

    beat_t       sb[$];
    beat_t       e_mon;
    logic [31:0] seed = 32'h5EED_0000;
    bit          mode = 1'b0;
    bit          first_flag = 1'b0;
    bit          stalled = 1'b0;
    logic [63:0] held_d;
    logic        held_l;
    int errors = 0, checks = 0, cyc = 0;
    int beats = 0, rd_cnt = 0, done_cnt = 0, exp_addr = 0;
    int first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0, rd_cyc = 0, last_rd_addr = 0;

    forwarder_reader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .buf_valid(buf_valid),
        .byte_length(byte_length),
        .forwarder_rd_addr(rd_addr),
        .forwarder_rd_en(rd_en),
        .forwarder_rd_data(rd_data),
        .forwarder_done(done),
        .m_tdata(m_tdata),
`ifdef FWD_TKEEP_EN
        .m_tkeep(m_tkeep),
`endif
        .m_tlast(m_tlast),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Packet memory: one-cycle read latency, garbage when not strobed.
    always @(posedge clk)
        rd_data <= rd_en ? {seed, 24'h0, 8'(rd_addr)} : 64'hBAD0_BAD0_BAD0_BAD0;

    initial forever begin
        @(posedge clk);
        #1 m_tready = mode ? ~m_tready : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_fill(input int len);
        int l, w, n;
        beat_t e;
        l = len > 128 ? 128 : len;
        w = (l + 7) / 8;
        n = ((l - 1) % 8) + 1;
        for (int i = 0; i < w; i++) begin
            e.d = {seed, 24'h0, 8'(i)};
            e.l = (i == w - 1);
            e.k = e.l ? 8'hFF << (8 - n) : 8'hFF;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                exp_addr = 0;
            end
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(exp_addr));
                exp_addr++;
                rd_cnt++;
                rd_cyc = cyc;
                last_rd_addr = int'(rd_addr);
            end
            if (stalled) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data", m_tdata, held_d);
                check("stall_last", 64'(m_tlast), 64'(held_l));
            end
            if (m_tvalid && m_tready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    check("tdata", m_tdata, e_mon.d);
                    check("tlast", 64'(m_tlast), 64'(e_mon.l));
`ifdef FWD_TKEEP_EN
                    check("tkeep", 64'(m_tkeep), 64'(e_mon.k));
`endif
                end
                beats++;
                last_beat_cyc = cyc;
                if (first_flag) begin
                    first_beat_cyc = cyc;
                    first_flag = 1'b0;
                end
            end
            stalled = m_tvalid && !m_tready;
            held_d = m_tdata;
            held_l = m_tlast;
        end
    end

    task automatic run_pkt(input int len, input bit tog);
        int l, w, s, b0, r0, d0;
        l = len > 128 ? 128 : len;
        w = (l + 7) / 8;
        seed++;
        sb_fill(len);
        b0 = beats; r0 = rd_cnt; d0 = done_cnt;
        exp_addr = 0; first_flag = 1'b1; mode = tog;
        @(posedge clk);
        #1 buf_valid = 1'b1; byte_length = 8'(len);
        @(posedge clk);
        #1 s = cyc; buf_valid = 1'b0;
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        mode = 1'b0;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("beat_count", 64'(beats - b0), 64'(w));
        check("rd_count", 64'(rd_cnt - r0), 64'(w));
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (w > 0) check("last_addr", 64'(last_rd_addr), 64'(w - 1));
        if (!tog && w > 0) begin
            check("first_valid_lat", 64'(first_beat_cyc - s), 64'd2);
            check("beat_span", 64'(last_beat_cyc - first_beat_cyc), 64'(w - 1));
            check("done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);
        end
        if (w == 0) check("done_lat_empty", 64'(done_cyc - s), 64'd1 - 64'd1);
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int b0, d0, r1, dc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {59'd0, rd_en, done, m_tvalid, m_tlast, 1'b0}, 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_pkt(20, 1'b0);
        run_pkt(64, 1'b1);
        run_pkt(0, 1'b0);
        run_pkt(200, 1'b0);
        run_pkt(13, 1'b1);

        // Reset in the middle of an 8-beat packet.
        seed++;
        sb_fill(64);
        b0 = beats; d0 = done_cnt; exp_addr = 0; mode = 1'b0;
        @(posedge clk);
        #1 buf_valid = 1'b1; byte_length = 8'd64;
        @(posedge clk);
        #1 buf_valid = 1'b0;
        for (int k = 0; k < 100 && beats - b0 < 3; k++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ctrl", {59'd0, rd_en, done, m_tvalid, m_tlast, 1'b0}, 64'd0);
        check("midrst_addr", 64'(rd_addr), 64'd0);
        check("midrst_tdata", m_tdata, 64'd0);
`ifdef FWD_TKEEP_EN
        check("midrst_tkeep", 64'(m_tkeep), 64'd0);
`endif
        sb.delete();
        exp_addr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        check("midrst_beats", 64'(beats - b0), 64'd3);
        run_pkt(8, 1'b0);

        // buf_valid held high across two packets.
        seed++;
        sb_fill(16);
        sb_fill(16);
        d0 = done_cnt; exp_addr = 0;
        @(posedge clk);
        #1 buf_valid = 1'b1; byte_length = 8'd16;
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clk);
        dc = done_cyc; r1 = rd_cnt;
        for (int k = 0; k < 20 && rd_cnt == r1; k++) @(posedge clk);
        #1 buf_valid = 1'b0;
        check("swap_gap", 64'(rd_cyc - dc >= 2), 64'd1);
        for (int k = 0; k < 100 && done_cnt < d0 + 2; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("swap_done_count", 64'(done_cnt - d0), 64'd2);
        check("swap_sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
